// File: rtl/cdc_scan_sequencer.sv
// Capacitance-to-digital scan sequencer: round-robin discharge/charge/sample per channel, averaged result on valid/ready.
// Optional CDC_BUBBLE_CHECK_EN adds o_bubble_err, a sticky flag for non-thermometer comparator samples.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for i_start with a non-empty channel mask
// S_DIS     | discharge switch closed for DIS_CYC clocks
// S_CHG     | charge/excite enabled for SETTLE_CYC clocks
// S_SMP     | one clock: encode i_cmp_in and accumulate
// S_RPT     | result presented, front end idle until the handshake

module cdc_scan_sequencer #(
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int DIS_CYC    = 4,
    parameter int SETTLE_CYC = 8,
    parameter int LOG2_AVG   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [NCH-1:0]        i_chan_en,
    input  logic [7:0]            i_cmp_in,
    output logic [CHW-1:0]        o_ch_sel,
    output logic                  o_discharge,
    output logic                  o_charge_en,
    output logic                  o_busy,
    output logic [3+LOG2_AVG-1:0] o_res_data,
    output logic [CHW-1:0]        o_res_chan,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
`ifdef CDC_BUBBLE_CHECK_EN
    output logic                  o_bubble_err,
`endif
    output logic                  o_no_hit
);

    localparam int AW   = 3 + LOG2_AVG;
    localparam int CNTW = LOG2_AVG + 1;
    localparam logic [CNTW-1:0] AVG_CNT = CNTW'(1 << LOG2_AVG);
    localparam logic [7:0]      PH_DIS  = 8'(DIS_CYC - 1);
    localparam logic [7:0]      PH_SET  = 8'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIS,
        S_CHG,
        S_SMP,
        S_RPT
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [NCH-1:0]  r_mask, w_mask_nxt;
    logic [CHW-1:0]  r_ch_sel, w_ch_nxt;
    logic [7:0]      r_phase, w_phase_nxt;
    logic [AW-1:0]   r_acc, w_acc_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt;
    logic            r_no_hit, w_no_hit_nxt;

    logic [2:0]      w_code;
    logic [CNTW-1:0] w_cnt_inc;
    logic [CHW-1:0]  w_first_ch;
    logic [CHW-1:0]  w_next_ch;
    logic            w_next_vld;

`ifdef CDC_BUBBLE_CHECK_EN
    logic            r_bubble, w_bubble_nxt;
    logic            w_bubble;

    // A valid thermometer code is a run of ones from bit 0, so adding 1 clears every set bit.
    assign w_bubble = |(i_cmp_in & (i_cmp_in + 8'd1));
`endif

    assign w_cnt_inc = r_cnt + CNTW'(1);

    always_comb begin
        w_code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (i_cmp_in[i]) w_code = 3'(i);
        end
    end

    // Downward scan so the lowest qualifying index is the one that sticks.
    always_comb begin
        w_first_ch = '0;
        w_next_ch  = '0;
        w_next_vld = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_chan_en[i]) w_first_ch = CHW'(i);
            if (r_mask[i] && (CHW'(i) > r_ch_sel)) begin
                w_next_ch  = CHW'(i);
                w_next_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mask_nxt   = r_mask;
        w_ch_nxt     = r_ch_sel;
        w_phase_nxt  = r_phase;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_no_hit_nxt = r_no_hit;
`ifdef CDC_BUBBLE_CHECK_EN
        w_bubble_nxt = r_bubble;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start && (|i_chan_en)) begin
                    w_state_nxt = S_DIS;
                    w_mask_nxt  = i_chan_en;
                    w_ch_nxt    = w_first_ch;
                    w_phase_nxt = PH_DIS;
                end
            end
            S_DIS: begin
                if (r_phase == 8'd0) begin
                    w_state_nxt = S_CHG;
                    w_phase_nxt = PH_SET;
                end else begin
                    w_phase_nxt = r_phase - 8'd1;
                end
            end
            S_CHG: begin
                if (r_phase == 8'd0) begin
                    w_state_nxt = S_SMP;
                end else begin
                    w_phase_nxt = r_phase - 8'd1;
                end
            end
            S_SMP: begin
                w_acc_nxt = r_acc + AW'(w_code);
                w_cnt_nxt = w_cnt_inc;
                if (i_cmp_in == 8'd0) w_no_hit_nxt = 1'b1;
`ifdef CDC_BUBBLE_CHECK_EN
                if (w_bubble) w_bubble_nxt = 1'b1;
`endif
                if (w_cnt_inc == AVG_CNT) begin
                    w_state_nxt = S_RPT;
                end else begin
                    w_state_nxt = S_DIS;
                    w_phase_nxt = PH_DIS;
                end
            end
            S_RPT: begin
                if (i_res_ready) begin
                    w_acc_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_no_hit_nxt = 1'b0;
`ifdef CDC_BUBBLE_CHECK_EN
                    w_bubble_nxt = 1'b0;
`endif
                    if (w_next_vld) begin
                        w_ch_nxt    = w_next_ch;
                        w_state_nxt = S_DIS;
                        w_phase_nxt = PH_DIS;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mask   <= '0;
            r_ch_sel <= '0;
            r_phase  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_no_hit <= 1'b0;
`ifdef CDC_BUBBLE_CHECK_EN
            r_bubble <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_mask   <= w_mask_nxt;
            r_ch_sel <= w_ch_nxt;
            r_phase  <= w_phase_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_no_hit <= w_no_hit_nxt;
`ifdef CDC_BUBBLE_CHECK_EN
            r_bubble <= w_bubble_nxt;
`endif
        end
    end

    assign o_ch_sel    = r_ch_sel;
    assign o_discharge = (r_state == S_DIS);
    assign o_charge_en = (r_state == S_CHG);
    assign o_busy      = (r_state != S_IDLE);
    assign o_res_data  = r_acc;
    assign o_res_chan  = r_ch_sel;
    assign o_res_valid = (r_state == S_RPT);
    assign o_no_hit    = r_no_hit;
`ifdef CDC_BUBBLE_CHECK_EN
    assign o_bubble_err = r_bubble;
`endif

endmodule
